// File: rtl/enemy_formation_pkg.sv
// Shared constants for the enemy formation renderer: screen limits, march
// direction and the two 8x8 invader bitmaps (bit x of row y = pixel (x, y)).
package enemy_formation_pkg;

  localparam int SCREEN_W = 640;
  localparam int BOTTOM_Y = 440;

  typedef enum logic {
    MARCH_R,
    MARCH_L
  } dir_t;

  // Element [y] is bitmap row y; element 0 is the rightmost byte.
  localparam logic [7:0][7:0] SPRITE_F0 = {
    8'hA5, 8'h5A, 8'h24, 8'hFF, 8'hF3, 8'hFF, 8'h7E, 8'h3C
  };
  localparam logic [7:0][7:0] SPRITE_F1 = {
    8'h42, 8'h81, 8'h42, 8'hFF, 8'hF3, 8'hFF, 8'h7E, 8'h3C
  };

endpackage

// File: rtl/enemy_formation_sprite_rom.sv
// Combinational invader bitmap lookup: (anim frame, row, column) -> lit.
module enemy_formation_sprite_rom
  import enemy_formation_pkg::*;
(
  input  logic       anim,
  input  logic [2:0] oy,
  input  logic [2:0] ox,
  output logic       lit
);

  assign lit = anim ? SPRITE_F1[oy][ox] : SPRITE_F0[oy][ox];

endmodule

// File: rtl/enemy_formation.sv
// Marching ROWS x COLS invader grid: movement FSM, alive mask with hit
// handling, invasion detection and a one-cycle-latency pixel renderer.
module enemy_formation
  import enemy_formation_pkg::*;
#(
  parameter int          ROWS      = 4,
  parameter int          COLS      = 8,
  parameter int          SCALE     = 2,
  parameter int          SPACING_X = 32,
  parameter int          SPACING_Y = 32,
  parameter int          START_X   = 64,
  parameter int          START_Y   = 48,
  parameter int          STEP_X    = 2,
  parameter int          STEP_Y    = 8,
  parameter int          MOVE_DIV  = 30,
  parameter logic [23:0] COLOR     = 24'hFFFFFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic [9:0]                      h_counter,
  input  logic [9:0]                      v_counter,
  input  logic                            hit_valid,
  input  logic [$clog2(ROWS)-1:0]         hit_row,
  input  logic [$clog2(COLS)-1:0]         hit_col,
  output logic [7:0]                      R,
  output logic [7:0]                      G,
  output logic [7:0]                      B,
  output logic                            pixel_on,
  output logic [9:0]                      form_x,
  output logic [9:0]                      form_y,
  output logic [$clog2(ROWS*COLS+1)-1:0]  alive_count,
  output logic                            all_dead,
  output logic                            reached_bottom
);

  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int LSX = $clog2(SPACING_X);
  localparam int LSY = $clog2(SPACING_Y);
  localparam int LSC = $clog2(SCALE);
  localparam int MCW = $clog2(MOVE_DIV + 1);
  localparam int AW  = $clog2(ROWS * COLS + 1);

  localparam logic [10:0] GRID_W = 11'(COLS * SPACING_X);
  localparam logic [10:0] GRID_H = 11'(ROWS * SPACING_Y);
  localparam logic [10:0] SPR    = 11'(8 * SCALE);
  localparam logic [10:0] MASK_X = 11'(SPACING_X - 1);
  localparam logic [10:0] MASK_Y = 11'(SPACING_Y - 1);
  localparam logic [10:0] SCR_W  = 11'(SCREEN_W);
  localparam logic [10:0] BOT    = 11'(BOTTOM_Y);
  localparam logic [10:0] SX     = 11'(STEP_X);
  localparam logic [RW:0] ROWS_L = (RW + 1)'(ROWS);
  localparam logic [CW:0] COLS_L = (CW + 1)'(COLS);

  logic [ROWS-1:0][COLS-1:0] alive;
  dir_t                      dir;
  logic                      anim;
  logic [MCW-1:0]            move_cnt;

  // Renderer: locate the pixel in the grid, then in the cell, then in the bitmap.
  logic [10:0]   dx, dy, offx, offy;
  logic          in_grid, in_sprite, lit, lit_next;
  logic [CW-1:0] cell_c;
  logic [RW-1:0] cell_r;

  assign dx        = {1'b0, h_counter} - {1'b0, form_x};
  assign dy        = {1'b0, v_counter} - {1'b0, form_y};
  assign in_grid   = (h_counter >= form_x) && (dx < GRID_W) &&
                     (v_counter >= form_y) && (dy < GRID_H);
  assign cell_c    = dx[LSX +: CW];
  assign cell_r    = dy[LSY +: RW];
  assign offx      = dx & MASK_X;
  assign offy      = dy & MASK_Y;
  assign in_sprite = (offx < SPR) && (offy < SPR);

  enemy_formation_sprite_rom u_rom (
    .anim (anim),
    .oy   (offy[LSC +: 3]),
    .ox   (offx[LSC +: 3]),
    .lit  (lit)
  );

  assign lit_next = in_grid && in_sprite && lit && alive[cell_r][cell_c];

  // Extent of the surviving enemies, used for edge and invasion checks.
  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;
  logic [CW-1:0]   lc, rc;
  logic [RW-1:0]   br;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    col_any = '0;
    row_any = '0;
    lc      = '0;
    rc      = '0;
    br      = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        col_any[c] = col_any[c] | alive[r][c];
        row_any[r] = row_any[r] | alive[r][c];
      end
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lc = CW'(c);
    for (int c = 0; c < COLS; c++)      if (col_any[c]) rc = CW'(c);
    for (int r = 0; r < ROWS; r++)      if (row_any[r]) br = RW'(r);
  end

  logic right_hit, left_hit, bottom_hit, tick_wrap, step, hit_ok;

  assign right_hit  = ({1'b0, form_x} + (11'(rc) << LSX) + SPR + SX) > SCR_W;
  assign left_hit   = ({1'b0, form_x} + (11'(lc) << LSX)) < SX;
  assign bottom_hit = (|row_any) && (({1'b0, form_y} + (11'(br) << LSY) + SPR) >= BOT);
  assign tick_wrap  = frame_tick && (move_cnt == MCW'(MOVE_DIV - 1));
  assign step       = tick_wrap && !all_dead && !reached_bottom;
  assign hit_ok     = hit_valid && ({1'b0, hit_row} < ROWS_L) &&
                      ({1'b0, hit_col} < COLS_L) && alive[hit_row][hit_col];
  assign all_dead   = (alive_count == '0);

  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      form_x         <= 10'(START_X);
      form_y         <= 10'(START_Y);
      alive          <= '1;
      alive_count    <= AW'(ROWS * COLS);
      dir            <= MARCH_R;
      anim           <= 1'b0;
      move_cnt       <= '0;
      reached_bottom <= 1'b0;
      pixel_on       <= 1'b0;
      R              <= '0;
      G              <= '0;
      B              <= '0;
    end else begin
      if (frame_tick) move_cnt <= tick_wrap ? '0 : move_cnt + MCW'(1);

      // Edge checks use the pre-hit mask, so a same-cycle hit cannot alter this step.
      if (step) begin
        anim <= ~anim;
        if (dir == MARCH_R) begin
          if (right_hit) begin
            form_y <= form_y + 10'(STEP_Y);
            dir    <= MARCH_L;
          end else begin
            form_x <= form_x + 10'(STEP_X);
          end
        end else begin
          if (left_hit) begin
            form_y <= form_y + 10'(STEP_Y);
            dir    <= MARCH_R;
          end else begin
            form_x <= form_x - 10'(STEP_X);
          end
        end
      end

      if (hit_ok) begin
        alive[hit_row][hit_col] <= 1'b0;
        alive_count             <= alive_count - AW'(1);
      end

      if (bottom_hit) reached_bottom <= 1'b1;

      pixel_on <= lit_next;
      R        <= lit_next ? COLOR[23:16] : 8'h00;
      G        <= lit_next ? COLOR[15:8]  : 8'h00;
      B        <= lit_next ? COLOR[7:0]   : 8'h00;
    end
  end

endmodule

// File: doc/enemy_formation.md
Name: enemy_formation

Overview:
- Renders a ROWS x COLS grid of scaled 8x8 invader sprites onto the VGA pixel stream.
- The grid marches horizontally, descends at the screen edges and alternates between two animation frames on each step.
- Keeps a per-enemy alive mask that is cleared by hit reports from the shot/collision logic.
- Sits between the VGA timing generator and the per-layer colour mux; replaces the single fixed-Y enemy renderer.

Parameters:
- ROWS, 4, formation rows
- COLS, 8, formation columns
- SCALE, 2, sprite pixel magnification; power of two
- SPACING_X, 32, horizontal cell pitch in pixels; power of two, >= 8*SCALE
- SPACING_Y, 32, vertical cell pitch in pixels; power of two, >= 8*SCALE
- START_X, 64, formation origin X after reset
- START_Y, 48, formation origin Y after reset
- SCREEN_W, 640, right boundary, exclusive
- BOTTOM_Y, 440, invasion line
- STEP_X, 2, pixels per horizontal step
- STEP_Y, 8, pixels per descent
- MOVE_DIV, 30, frame_ticks per movement step
- COLOR, 24'hFFFFFF, RGB of lit sprite pixels

Ports:
- clk  in  1  pixel clock
- reset  in  1  reset, synchronous, active-high
- frame_tick  in  1  one-cycle pulse per frame (vsync start)
- h_counter  in  10  current pixel X
- v_counter  in  10  current pixel Y
- hit_valid  in  1  one-cycle hit report
- hit_row  in  $clog2(ROWS)  hit enemy row
- hit_col  in  $clog2(COLS)  hit enemy column
- R, G, B  out  8 each  pixel colour, registered
- pixel_on  out  1  lit sprite pixel, registered, aligned with R/G/B
- form_x  out  10  current formation origin X
- form_y  out  10  current formation origin Y
- alive_count  out  $clog2(ROWS*COLS+1)  enemies remaining
- all_dead  out  1  alive_count == 0
- reached_bottom  out  1  sticky invasion flag

Behaviour:
- Reset values:
  - form_x = START_X, form_y = START_Y.
  - Alive mask all ones; alive_count = ROWS*COLS.
  - Direction = RIGHT, anim = 0, move_cnt = 0.
  - R/G/B = 0, pixel_on = 0, all_dead = 0, reached_bottom = 0.
- Rendering (1-cycle latency):
  - A pixel lies in the grid if form_x <= h < form_x + COLS*SPACING_X and form_y <= v < form_y + ROWS*SPACING_Y.
  - Cell index: col = (h - form_x) >> log2(SPACING_X), row likewise in Y. Offset inside the cell = low bits.
  - Offset >= 8*SCALE is gap and renders black.
  - Bitmap coordinates: ox = offset_x >> log2(SCALE), oy likewise.
  - Frame 0 bitmap rows 0-7:
    - row 0: x2-5
    - row 1: x1-6
    - row 2: x0-7
    - row 3: x0,1,4-7
    - row 4: x0-7
    - row 5: x2,5
    - row 6: x1,3,4,6
    - row 7: x0,2,5,7
  - Frame 1: rows 0-4 identical; row 5: x1,6; row 6: x0,7; row 7: x1,6.
  - Lit pixel of an alive enemy -> pixel_on = 1 and RGB = COLOR; otherwise 0.
  - All arithmetic is done in 11 bits to avoid wrap.
- Move counter:
  - move_cnt increments on each frame_tick.
  - When frame_tick arrives with move_cnt == MOVE_DIV-1, move_cnt returns to 0 and a step fires.
  - Steps are suppressed while all_dead or reached_bottom is set.
- Step FSM (states MARCH_R, MARCH_L), evaluated on step fire:
  - lc/rc = leftmost/rightmost column containing any alive enemy.
  - MARCH_R: if form_x + rc*SPACING_X + 8*SCALE + STEP_X > SCREEN_W, descend: form_y += STEP_Y and go to MARCH_L. Else form_x += STEP_X.
  - MARCH_L: if form_x + lc*SPACING_X < STEP_X, descend: form_y += STEP_Y and go to MARCH_R. Else form_x -= STEP_X.
  - anim toggles on every step, including descents.
- Hits:
  - On hit_valid with an alive target: clear the bit and decrement alive_count.
  - A hit on a dead enemy, or an out-of-range index, is ignored.
- Bottom detection:
  - br = lowest row with any alive enemy.
  - When form_y + br*SPACING_Y + 8*SCALE >= BOTTOM_Y, set reached_bottom the next cycle.
  - reached_bottom stays set until reset.
- Simultaneous hit and step:
  - Both apply in the same cycle.
  - Edge and bottom checks use the pre-hit mask.
- Reset mid-line or mid-step: all state returns to reset values on that edge; no partial step.

Decomposition:
- Shared package holds:
  - the two sprite bitmaps as 8x8 constants;
  - the direction enum;
  - the screen constants SCREEN_W and BOTTOM_Y.
- One sub-module, sprite_rom: combinational (anim, oy, ox) -> lit.
  - Reused later by other enemy types.

Test Plan:
- Reset, then scan v=48, h=64..79 -> pixel_on asserted one cycle after h=68..75 only; RGB = FFFFFF when lit, 0 otherwise.
- MOVE_DIV=2, issue 2 frame_ticks -> form_x = 66 and anim = 1; one more tick -> no change.
- Drive steps from form_x = 64 -> form_x stops at 400. Next step gives form_y = 56, direction left, form_x still 400; the following step gives 398.
- Hit all 4 enemies in column 7 -> alive_count = 28, and the right edge is now reached at form_x = 432. Hit (0,7) again -> alive_count unchanged.
- Hit all 32 enemies -> all_dead = 1, and further frame_ticks leave form_x/form_y frozen.
- Force descents until form_y + 96 + 16 >= 440 -> reached_bottom = 1 and stays set. Then assert reset -> flag clears and form_y returns to 48.
